// File: rtl/add_sub_norm_arbiter.sv
// Round-robin arbiter feeding one shared 16-bit leading-zero detector and normalizing shifter; optional counters under ADD_SUB_NORM_STATS_EN.
// Two register stages from handshake to response; a stalled output holds both stages and deasserts every o_req_ready.
module add_sub_norm_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int DATA_W  = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic                      o_rsp_valid,
  output logic [ID_W-1:0]           o_rsp_id,
  output logic [3:0]                o_rsp_pos,
  output logic                      o_rsp_zero,
  output logic [DATA_W-1:0]         o_rsp_norm,
  input  logic                      i_rsp_ready
`ifdef ADD_SUB_NORM_STATS_EN
  ,
  output logic [15:0]               o_zero_cnt,
  output logic [15:0]               o_stall_cnt
`endif
);

  typedef struct packed {
    logic              vld;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] dat;
  } s1_t;

  typedef struct packed {
    logic              vld;
    logic [ID_W-1:0]   id;
    logic [3:0]        pos;
    logic              zero;
    logic [DATA_W-1:0] norm;
  } rsp_t;

  s1_t               s1_q, s1_d;
  rsp_t              rsp_q, rsp_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;

  logic              s1_adv, s2_adv;
  logic              gnt_vld, hs;
  logic [ID_W-1:0]   gnt_id;
  logic [DATA_W-1:0] gnt_dat;
  int                idx;

  logic [3:0]        lz_pos;
  logic [DATA_W-1:0] lz_tmp;
  logic [DATA_W-1:0] sh_norm;

  assign s2_adv = !rsp_q.vld || i_rsp_ready;
  assign s1_adv = !s1_q.vld || s2_adv;

  // Rotating search starting at the pointer; the first valid requester wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_dat = '0;
    idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_vld && |((i_req_valid >> idx) & NUM_REQ'(1))) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
        gnt_dat = DATA_W'(i_req_data >> (idx * DATA_W));
      end
    end
  end

  assign hs          = gnt_vld && s1_adv && i_rst_n;
  assign o_req_ready = hs ? (NUM_REQ'(1) << gnt_id) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  end

  always_comb begin
    s1_d = s1_q;
    if (s1_adv) begin
      s1_d.vld = hs;
      if (hs) begin
        s1_d.id  = gnt_id;
        s1_d.dat = gnt_dat;
      end
    end
  end

  // Leading-zero count by shifting until the MSB is set; zero input leaves pos at 0.
  always_comb begin
    lz_pos = '0;
    lz_tmp = s1_q.dat;
    for (int k = 0; k < DATA_W - 1; k++) begin
      if (!lz_tmp[DATA_W-1] && (lz_tmp != '0)) begin
        lz_tmp = lz_tmp << 1;
        lz_pos = lz_pos + 4'd1;
      end
    end
  end

  assign sh_norm = s1_q.dat << lz_pos;

  always_comb begin
    rsp_d = rsp_q;
    if (s2_adv) begin
      rsp_d.vld  = s1_q.vld;
      rsp_d.id   = s1_q.id;
      rsp_d.pos  = lz_pos;
      rsp_d.zero = (s1_q.dat == '0);
      rsp_d.norm = sh_norm;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q  <= '0;
      rsp_q <= '0;
      ptr_q <= '0;
    end else begin
      s1_q  <= s1_d;
      rsp_q <= rsp_d;
      ptr_q <= ptr_d;
    end
  end

  assign o_rsp_valid = rsp_q.vld;
  assign o_rsp_id    = rsp_q.id;
  assign o_rsp_pos   = rsp_q.pos;
  assign o_rsp_zero  = rsp_q.zero;
  assign o_rsp_norm  = rsp_q.norm;

`ifdef ADD_SUB_NORM_STATS_EN
  logic [15:0] zero_cnt_q, zero_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Both counters stick at all-ones rather than wrapping.
  always_comb begin
    zero_cnt_d  = zero_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (rsp_q.vld && i_rsp_ready && rsp_q.zero && (zero_cnt_q != 16'hFFFF))
      zero_cnt_d = zero_cnt_q + 16'd1;
    if (rsp_q.vld && !i_rsp_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zero_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      zero_cnt_q  <= zero_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_zero_cnt  = zero_cnt_q;
  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_add_sub_norm_arbiter.sv
// Randomized and directed bench for add_sub_norm_arbiter against a behavioural model and an in-order scoreboard.
module tb_add_sub_norm_arbiter;
  localparam int N = 4;

  logic          i_clk;
  logic          i_rst_n;
  logic [N-1:0]  i_req_valid;
  logic [N*16-1:0] i_req_data;
  logic [N-1:0]  o_req_ready;
  logic          o_rsp_valid;
  logic [1:0]    o_rsp_id;
  logic [3:0]    o_rsp_pos;
  logic          o_rsp_zero;
  logic [15:0]   o_rsp_norm;
  logic          i_rsp_ready;
`ifdef ADD_SUB_NORM_STATS_EN
  logic [15:0]   o_zero_cnt;
  logic [15:0]   o_stall_cnt;
`endif

  add_sub_norm_arbiter #(.NUM_REQ(N), .ID_W(2), .DATA_W(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready),
    .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_pos(o_rsp_pos),
    .o_rsp_zero(o_rsp_zero), .o_rsp_norm(o_rsp_norm),
    .i_rsp_ready(i_rsp_ready)
`ifdef ADD_SUB_NORM_STATS_EN
    , .o_zero_cnt(o_zero_cnt), .o_stall_cnt(o_stall_cnt)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [15:0] dat;
  } item_t;
  item_t acc_q[$];

  // Model: output slot and middle slot, plus pointer and stats.
  int          m_ptr;
  logic        m_ov, m_s1v;
  int          m_oid, m_s1id;
  logic [15:0] m_odat, m_s1dat;
  int          m_zc, m_sc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lzc(input logic [15:0] x);
    int n = 0;
    if (x == 16'h0) return 0;
    while (!x[15]) begin
      x = x << 1;
      n++;
    end
    return n;
  endfunction

  function automatic logic [15:0] norm_of(input logic [15:0] x);
    logic [15:0] r;
    r = x << lzc(x);
    return r;
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 3))
      0: return 16'h0000;
      1: return 16'h0001 << $urandom_range(0, 15);
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_ov = 0; m_s1v = 0; m_oid = 0; m_s1id = 0;
    m_odat = 0; m_s1dat = 0; m_zc = 0; m_sc = 0;
    acc_q.delete();
  endtask

  // Check DUT outputs for the current cycle, then advance the model across the next edge.
  task automatic compare_and_advance();
    int g;
    int idx;
    logic s2a, s1a;
    logic [N-1:0] exp_rdy;
    item_t it;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && i_req_valid[idx]) g = idx;
    end
    s2a = !m_ov || i_rsp_ready;
    s1a = !m_s1v || s2a;
    exp_rdy = (g >= 0 && s1a && i_rst_n) ? N'(1) << g : '0;

    chk("req_ready", o_req_ready, exp_rdy);
    chk("rsp_valid", o_rsp_valid, m_ov);
    if (m_ov) begin
      chk("rsp_id", o_rsp_id, m_oid);
      chk("rsp_pos", o_rsp_pos, lzc(m_odat));
      chk("rsp_zero", o_rsp_zero, m_odat == 16'h0);
      chk("rsp_norm", o_rsp_norm, norm_of(m_odat));
    end
`ifdef ADD_SUB_NORM_STATS_EN
    chk("zero_cnt", o_zero_cnt, m_zc);
    chk("stall_cnt", o_stall_cnt, m_sc);
`endif
    if (o_rsp_valid && i_rsp_ready && i_rst_n) begin
      if (acc_q.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        it = acc_q.pop_front();
        chk("sb_id", o_rsp_id, it.id);
        chk("sb_norm", o_rsp_norm, norm_of(it.dat));
      end
    end

    if (!i_rst_n) begin
      model_reset();
    end else begin
      if (m_ov && i_rsp_ready && m_odat == 16'h0 && m_zc < 16'hFFFF) m_zc++;
      if (m_ov && !i_rsp_ready && m_sc < 16'hFFFF) m_sc++;
      if (s2a) begin
        m_ov = m_s1v; m_oid = m_s1id; m_odat = m_s1dat;
      end
      if (s1a) begin
        m_s1v = (exp_rdy != '0);
        if (exp_rdy != '0) begin
          m_s1id  = g;
          m_s1dat = i_req_data[g*16 +: 16];
          it.id = g; it.dat = m_s1dat;
          acc_q.push_back(it);
          m_ptr = (g + 1) % N;
        end
      end
    end
  endtask

  task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*16-1:0] d, input logic rr);
    @(posedge i_clk);
    #1;
    i_rst_n = rst; i_req_valid = v; i_req_data = d; i_rsp_ready = rr;
    @(negedge i_clk);
    compare_and_advance();
  endtask

  function automatic logic [N*16-1:0] rand_data();
    return {rand16(), rand16(), rand16(), rand16()};
  endfunction

  logic [3:0] rr_seq [4];

  initial begin
    rr_seq[0] = 4'h2; rr_seq[1] = 4'h4; rr_seq[2] = 4'h8; rr_seq[3] = 4'h1;
    i_rst_n = 0; i_req_valid = '0; i_req_data = '0; i_rsp_ready = 0;
    model_reset();

    // Reset state: ready held low even with requests pending.
    step(0, 4'hF, rand_data(), 1);
    chk("rst_valid", o_rsp_valid, 0);
    chk("rst_ready", o_req_ready, 0);
    step(0, 4'h0, '0, 1);

    // Single request 0x0100 from req0.
    step(1, 4'b0001, {48'h0, 16'h0100}, 1);
    chk("single_ready", o_req_ready, 4'b0001);
    step(1, 4'b0000, '0, 1);
    step(1, 4'b0000, '0, 1);
    chk("single_valid", o_rsp_valid, 1);
    chk("single_id", o_rsp_id, 0);
    chk("single_pos", o_rsp_pos, 7);
    chk("single_zero", o_rsp_zero, 0);
    chk("single_norm", o_rsp_norm, 16'h8000);

    // Zero then MSB-set inputs; pointer moves to 1 after each req0 grant.
    step(1, 4'b0001, {48'h0, 16'h0000}, 1);
    step(1, 4'b0001, {48'h0, 16'h8000}, 1);
    step(1, 4'b0000, '0, 1);
    chk("zero_valid", o_rsp_valid, 1);
    chk("zero_pos", o_rsp_pos, 0);
    chk("zero_flag", o_rsp_zero, 1);
    chk("zero_norm", o_rsp_norm, 16'h0000);
    step(1, 4'b0000, '0, 1);
    chk("msb_valid", o_rsp_valid, 1);
    chk("msb_pos", o_rsp_pos, 0);
    chk("msb_zero", o_rsp_zero, 0);
    chk("msb_norm", o_rsp_norm, 16'h8000);

    // All requesters valid: rotation continues from pointer 1.
    for (int i = 0; i < 8; i++) begin
      step(1, 4'hF, rand_data(), 1);
      chk("rr_grant", o_req_ready, rr_seq[i % 4]);
    end

    // Backpressure with both stages full, then release with requests still pending.
    for (int i = 0; i < 5; i++) begin
      step(1, 4'hF, rand_data(), 0);
      chk("bp_ready_low", o_req_ready, 0);
      chk("bp_valid_held", o_rsp_valid, 1);
    end
    for (int i = 0; i < 4; i++) step(1, 4'hF, rand_data(), 1);
    for (int i = 0; i < 3; i++) step(1, 4'h0, '0, 1);

    // Reset while two items are in flight.
    step(1, 4'b0001, rand_data(), 1);
    step(1, 4'b0010, rand_data(), 1);
    @(posedge i_clk);
    #1;
    i_rst_n = 0;
    #1;
    chk("arst_valid", o_rsp_valid, 0);
    chk("arst_ready", o_req_ready, 0);
    model_reset();
    step(0, 4'h0, '0, 1);
    step(1, 4'b1100, rand_data(), 1);
    chk("post_rst_grant", o_req_ready, 4'b0100);
    step(1, 4'b1100, rand_data(), 1);
    chk("post_rst_grant2", o_req_ready, 4'b1000);

    // Randomized traffic with random backpressure and withdrawn requests.
    for (int i = 0; i < 3000; i++)
      step(1, N'($urandom), rand_data(), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 4; i++) step(1, 4'h0, '0, 1);

`ifdef ADD_SUB_NORM_STATS_EN
    // Long stall to drive the stall counter into saturation.
    for (int i = 0; i < 66000; i++) step(1, 4'hF, rand_data(), 0);
    chk("stall_sat", o_stall_cnt, 16'hFFFF);
    for (int i = 0; i < 4; i++) step(1, 4'h0, '0, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_sub_norm_arbiter.md
Name: add_sub_norm_arbiter

Overview:
Shared normalization engine for the FFT butterfly add/sub lanes. NUM_REQ requesters issue raw 16-bit mantissa sums. The block picks one per cycle by round-robin and runs it through a leading-one/zero detector and a left normalizing shifter, which are instantiated once and shared. It returns the leading-zero count, the zero flag, the normalized mantissa and the requester ID over a 2-stage pipeline with valid/ready backpressure. It sits between the lane adders and the exponent-adjust/rounding logic.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width; must satisfy 2**ID_W >= NUM_REQ
DATA_W, 16, mantissa width; fixed at 16 (the detector is 16-bit)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_req_valid  input  NUM_REQ  per-requester valid
i_req_data  input  NUM_REQ*16  packed mantissas; requester k uses bits [16k+15:16k]
o_req_ready  output  NUM_REQ  one-hot accept; at most one bit high per cycle
o_rsp_valid  output  1  response valid
o_rsp_id  output  ID_W  index of the requester that issued the response
o_rsp_pos  output  4  leading-zero count (0..15)
o_rsp_zero  output  1  input was all zero
o_rsp_norm  output  16  data << pos
i_rsp_ready  input  1  downstream accept

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - Stage-1 and stage-2 valids = 0.
  - RR pointer = 0.
  - o_rsp_valid/id/pos/zero/norm = 0.
  - o_req_ready = 0 while in reset.
- Arbitration (combinational):
  - Search i_req_valid starting at the pointer and wrapping modulo NUM_REQ; the first set bit is the grant.
  - o_req_ready[g] = 1 only when a grant exists and s1_adv = 1.
  - A handshake is i_req_valid[g] & o_req_ready[g].
- Pipeline control:
  - s2_adv = !o_rsp_valid | i_rsp_ready.
  - s1_adv = !s1_valid | s2_adv.
- Stage 1 (register): on handshake capture data[g] and ID g, and set s1_valid=1. If s1_adv=1 with no handshake, set s1_valid=0. If s1_adv=0, hold.
- Stage 2 (register):
  - When s2_adv=1, load the following from s1, using the detector combinationally on s1 data:
    - o_rsp_valid = s1_valid
    - o_rsp_id = s1 ID
    - o_rsp_pos = leading-zero count
    - o_rsp_zero = (data==0)
    - o_rsp_norm = data << pos (16-bit, upper bits discarded)
  - For zero input: pos=0, zero=1, norm=0.
  - When s2_adv=0, all response outputs hold stable.
- Latency: 2 cycles from the handshake edge to o_rsp_valid=1. Sustained throughput is 1 per cycle when i_rsp_ready=1.
- RR pointer: updates only on a handshake, to (g+1) mod NUM_REQ. With no handshake (stall or no requests) the pointer holds.
- Boundaries:
  - Requester withdrawing valid without a handshake: allowed, no effect.
  - Single active requester: granted every cycle.
  - Full pipeline with i_rsp_ready=0: both stages hold and all o_req_ready = 0.
  - The i_rsp_ready rise and a new handshake in the same cycle both take effect; no bubble, no drop, no duplicate.
  - Reset asserted mid-operation: in-flight items are discarded and the pointer returns to 0.
- Ordering: responses leave in acceptance order.

Optional Feature:
ADD_SUB_NORM_STATS_EN
- Defined:
  - Adds output o_zero_cnt [15:0], a saturating count of responses with o_rsp_zero=1.
  - Adds output o_stall_cnt [15:0], a saturating count of cycles with o_rsp_valid=1 & i_rsp_ready=0.
  - A response counts when it is transferred (o_rsp_valid & i_rsp_ready).
  - Both counters reset to 0, saturate at 16'hFFFF, and do not wrap.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Single request, req0 data 16'h0100, i_rsp_ready=1 -> 2 cycles later: valid=1, id=0, pos=7, zero=0, norm=16'h8000.
- Zero and MSB cases, data 16'h0000 then 16'h8000 -> first response pos=0, zero=1, norm=0; second response pos=0, zero=0, norm=16'h8000.
- All 4 requesters valid continuously, i_rsp_ready=1 -> grants in order 0,1,2,3,0,...; responses back-to-back, one per cycle.
- Backpressure: i_rsp_ready=0 for 5 cycles with both stages full -> outputs stable, all o_req_ready=0, pointer frozen; after release, no loss, no duplicate, order preserved.
- Reset pulse while 2 items are in flight -> o_rsp_valid=0 immediately (asynchronous); after release, req2 and req3 valid -> req0 position searched first, req2 granted first.
- With ADD_SUB_NORM_STATS_EN, 3 zero inputs plus 4 stall cycles -> o_zero_cnt=3, o_stall_cnt=4; forced 70000 stall cycles -> o_stall_cnt=16'hFFFF.
